// File: rtl/alu_pkg.sv
// Definitions shared by the multi-cycle ALU execution units.
// Includes the FSM state encoding, the default datapath width and the Zhigh fill value.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  // Units that produce no high result word drive every Zhigh bit with this value.
  localparam logic ZHIGH_BIT = 1'b0;

endpackage

// File: rtl/seq_rol_unit_rol_step.sv
// Combinational rotate-left of a WIDTH-bit word by k positions, where k is 0..STEP.
// The rotating unit applies one of these steps on each clock.
module rol_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] data_o
);

  logic [2*WIDTH-1:0] doubled;
  logic               unused_low;

  // Shifting two copies side by side makes the bits leaving the top wrap into the bottom.
  assign doubled    = {data_i, data_i} << k_i;
  assign data_o     = doubled[2*WIDTH-1:WIDTH];
  assign unused_low = ^doubled[WIDTH-1:0];

endmodule

// File: rtl/seq_rol_unit.sv
// Multi-cycle rotate-left unit with a start/busy/done handshake.
// It rotates x left by (y mod WIDTH), up to STEP positions per clock, and writes the result to Zlow.
module seq_rol_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1,
  localparam int CW   = $clog2(WIDTH),
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Zlow,
  output logic [WIDTH-1:0] Zhigh
);

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_w;
  logic [WIDTH-1:0] zlow_q;
  logic             busy_q, done_q;
  logic [CW-1:0]    amount_w;
  logic             unused_y;

  assign amount_w = y[CW-1:0];
  assign unused_y = ^y[WIDTH-1:CW];

  always_comb begin
    k_w = KW'(STEP);
    if (32'(cnt_q) < STEP) begin
      k_w = KW'(cnt_q);
    end
    cnt_d = cnt_q - CW'(k_w);
  end

  rol_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_rol_step (
    .data_i (sreg_q),
    .k_i    (k_w),
    .data_o (sreg_d)
  );

  // Zlow is loaded only on entry to DONE, so partial rotations never appear on it.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      zlow_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sreg_q <= x;
            cnt_q  <= amount_w;
            busy_q <= 1'b1;
            if (amount_w == '0) begin
              zlow_q  <= x;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= ROTATE;
            end
          end
        end
        ROTATE: begin
          sreg_q <= sreg_d;
          cnt_q  <= cnt_d;
          if (cnt_d == '0) begin
            zlow_q  <= sreg_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Zlow  = zlow_q;
  assign Zhigh = {WIDTH{ZHIGH_BIT}};

endmodule

// File: tb/tb_seq_rol_unit.sv
// Directed testbench for seq_rol_unit, using a STEP=1 instance and a STEP=4 instance.
// Expected results and edge counts are worked out by hand.
module tb_seq_rol_unit;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start, start4;
  logic [31:0] x, y, x4, y4;
  logic        busy, done, busy4, done4;
  logic [31:0] Zlow, Zhigh, Zlow4, Zhigh4;

  int total = 0;
  int bad   = 0;

  seq_rol_unit #(.WIDTH(32), .STEP(1)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .Zlow    (Zlow),
    .Zhigh   (Zhigh)
  );

  seq_rol_unit #(.WIDTH(32), .STEP(4)) dut4 (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start4),
    .x       (x4),
    .y       (y4),
    .busy    (busy4),
    .done    (done4),
    .Zlow    (Zlow4),
    .Zhigh   (Zhigh4)
  );

  always #5 clock = ~clock;

  // Issue one request on the STEP=1 unit and wait (bounded) for done; returns one cycle after done.
  task automatic do_op(input logic [31:0] xv, input logic [31:0] yv,
                       output logic [31:0] z, output int edges,
                       output bit busyAlways, output bit zStable);
    logic [31:0] z0;
    z0 = Zlow;
    start = 1'b1; x = xv; y = yv;
    busyAlways = 1'b1; zStable = 1'b1; edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
      start = 1'b0;
      if (busy !== 1'b1) busyAlways = 1'b0;
      if (done !== 1'b1 && Zlow !== z0) zStable = 1'b0;
    end while (done !== 1'b1 && edges < 200);
    z = Zlow;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; start = 1'b0; x = '0; y = '0;
    start4 = 1'b0; x4 = '0; y4 = '0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (Zlow !== 32'h0) begin bad++; $display("FAIL reset_zlow got=%h want=00000000", Zlow); end
    total++; if (Zhigh !== 32'h0) begin bad++; $display("FAIL reset_zhigh got=%h want=00000000", Zhigh); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4 got=%b want=0", busy4); end
    #11 clear_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    logic [31:0] z; int e; bit bAll, zSt;
    do_op(32'h55555555, 32'd7, z, e, bAll, zSt);
    total++; if (z !== 32'hAAAAAAAA) begin bad++; $display("FAIL basic_zlow got=%h want=aaaaaaaa", z); end
    total++; if (e !== 8) begin bad++; $display("FAIL basic_edges got=%0d want=8", e); end
    total++; if (bAll !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bAll); end
    total++; if (zSt !== 1'b1) begin bad++; $display("FAIL basic_zlow_hidden got=%b want=1", zSt); end
    total++; if (Zhigh !== 32'h0) begin bad++; $display("FAIL basic_zhigh got=%h want=00000000", Zhigh); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b want=00", {busy, done}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] z; int e; bit bAll, zSt;
    do_op(32'h00000003, 32'd7, z, e, bAll, zSt);
    total++; if (z !== 32'h00000180) begin bad++; $display("FAIL b2b_first got=%h want=00000180", z); end
    do_op(32'hAAAAAAAA, 32'd7, z, e, bAll, zSt);
    total++; if (z !== 32'h55555555) begin bad++; $display("FAIL b2b_second got=%h want=55555555", z); end
    total++; if (e !== 8) begin bad++; $display("FAIL b2b_edges got=%0d want=8", e); end
  endtask

  task automatic test_boundaries();
    logic [31:0] z; int e; bit bAll, zSt;
    do_op(32'h00000001, 32'd31, z, e, bAll, zSt);
    total++; if (z !== 32'h80000000) begin bad++; $display("FAIL y31_zlow got=%h want=80000000", z); end
    total++; if (e !== 32) begin bad++; $display("FAIL y31_edges got=%0d want=32", e); end
    do_op(32'h00000001, 32'd32, z, e, bAll, zSt);
    total++; if (z !== 32'h00000001) begin bad++; $display("FAIL y32_zlow got=%h want=00000001", z); end
    total++; if (e !== 1) begin bad++; $display("FAIL y32_edges got=%0d want=1", e); end
    do_op(32'h00000001, 32'd33, z, e, bAll, zSt);
    total++; if (z !== 32'h00000002) begin bad++; $display("FAIL y33_zlow got=%h want=00000002", z); end
    total++; if (e !== 2) begin bad++; $display("FAIL y33_edges got=%0d want=2", e); end
  endtask

  task automatic test_start_held();
    int e;
    start = 1'b1; x = 32'h0000000F; y = 32'd4; e = 0;
    do begin
      @(posedge clock); #1;
      e++;
      if (e == 2) begin x = 32'hFFFF0000; y = 32'd1; end
    end while (done !== 1'b1 && e < 200);
    total++; if (e !== 5) begin bad++; $display("FAIL held_edges got=%0d want=5", e); end
    total++; if (Zlow !== 32'h000000F0) begin bad++; $display("FAIL held_first got=%h want=000000f0", Zlow); end
    @(posedge clock); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL held_not_accepted got=%b want=00", {busy, done}); end
    @(posedge clock); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_reaccept got=%b want=1", busy); end
    e = 0;
    while (done !== 1'b1 && e < 200) begin @(posedge clock); #1; e++; end
    total++; if (e !== 1) begin bad++; $display("FAIL held_second_edges got=%0d want=1", e); end
    total++; if (Zlow !== 32'hFFFE0001) begin bad++; $display("FAIL held_second got=%h want=fffe0001", Zlow); end
    @(posedge clock); #1;
  endtask

  task automatic test_abort();
    logic [31:0] z; int e; bit bAll, zSt, sawDone;
    start = 1'b1; x = 32'h1; y = 32'd20;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    #2 clear_n = 1'b0;
    #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_flags got=%b want=00", {busy, done}); end
    total++; if (Zlow !== 32'h0) begin bad++; $display("FAIL abort_zlow got=%h want=00000000", Zlow); end
    #10 clear_n = 1'b1;
    sawDone = 1'b0;
    repeat (25) begin @(posedge clock); #1; if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1; end
    total++; if (sawDone !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", sawDone); end
    do_op(32'h1, 32'd4, z, e, bAll, zSt);
    total++; if (z !== 32'h00000010) begin bad++; $display("FAIL abort_fresh got=%h want=00000010", z); end
    total++; if (e !== 5) begin bad++; $display("FAIL abort_fresh_edges got=%0d want=5", e); end
  endtask

  task automatic test_step4();
    int e;
    logic [31:0] amounts [3];
    logic [31:0] wantZ [3];
    int wantE [3];
    amounts = '{32'd7, 32'd8, 32'd0};
    wantZ   = '{32'h00000080, 32'h00000100, 32'h00000001};
    wantE   = '{3, 3, 1};
    for (int i = 0; i < 3; i++) begin
      start4 = 1'b1; x4 = 32'h1; y4 = amounts[i]; e = 0;
      do begin
        @(posedge clock); #1;
        e++;
        start4 = 1'b0;
      end while (done4 !== 1'b1 && e < 200);
      total++; if (e !== wantE[i]) begin bad++; $display("FAIL step4_edges_%0d got=%0d want=%0d", i, e, wantE[i]); end
      total++; if (Zlow4 !== wantZ[i]) begin bad++; $display("FAIL step4_zlow_%0d got=%h want=%h", i, Zlow4, wantZ[i]); end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundaries();
    test_start_held();
    test_abort();
    test_step4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
